// File: rtl/decode_pkg.sv
// Shared decode types: imm_sel encodings, opcode ranges, instruction field positions, decoded bundle.
// Imported by the decode stage and by later stages that re-decode opcodes.
package decode_pkg;

   localparam int INSTR_W = 32;
   localparam int OPW     = 6;

   typedef enum logic [1:0] {
      IMM_ZERO   = 2'b00,
      IMM_UPPER  = 2'b01,
      IMM_SEXT16 = 2'b10,
      IMM_SEXT21 = 2'b11
   } imm_sel_t;

   localparam logic [OPW-1:0] OP_RTYPE_LO  = 6'h00;
   localparam logic [OPW-1:0] OP_RTYPE_HI  = 6'h0F;
   localparam logic [OPW-1:0] OP_UPPER     = 6'h10;
   localparam logic [OPW-1:0] OP_ITYPE_LO  = 6'h11;
   localparam logic [OPW-1:0] OP_ITYPE_HI  = 6'h1F;
   localparam logic [OPW-1:0] OP_BRANCH_LO = 6'h20;
   localparam logic [OPW-1:0] OP_BRANCH_HI = 6'h27;

   localparam int A_LSB  = 0;
   localparam int A_W    = 5;
   localparam int B_LSB  = 5;
   localparam int B_W    = 5;
   localparam int C_LSB  = 10;
   localparam int C_W    = 11;
   localparam int RD_LSB = 21;
   localparam int RD_W   = 5;
   localparam int OP_LSB = 26;

   typedef struct packed {
      logic [A_W-1:0]  a;
      logic [B_W-1:0]  b;
      logic [C_W-1:0]  c;
      logic [RD_W-1:0] rd;
      imm_sel_t        imm_sel;
      logic            reg_write;
      logic            is_branch;
      logic            illegal;
   } dec_bundle_t;

   function automatic logic [OPW-1:0] get_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_LSB +: OPW];
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode -> decoded bundle; zero latency, no state, no backpressure.
// DECODE_ILLEGAL_TRAP_EN flags opcodes 0x28-0x3F as illegal; otherwise they decode as NOPs.
module opcode_decode
   import decode_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output dec_bundle_t        dec
);

   logic [OPW-1:0] op;

   assign op = get_op(instr);

   always_comb begin
      dec         = '0;
      dec.a       = instr[A_LSB  +: A_W];
      dec.b       = instr[B_LSB  +: B_W];
      dec.c       = instr[C_LSB  +: C_W];
      dec.rd      = instr[RD_LSB +: RD_W];
      dec.imm_sel = IMM_ZERO;
      case (op) inside
         [OP_RTYPE_LO:OP_RTYPE_HI]: begin
            dec.reg_write = 1'b1;
         end
         OP_UPPER: begin
            dec.imm_sel   = IMM_UPPER;
            dec.reg_write = 1'b1;
         end
         [OP_ITYPE_LO:OP_ITYPE_HI]: begin
            dec.imm_sel   = IMM_SEXT16;
            dec.reg_write = 1'b1;
         end
         [OP_BRANCH_LO:OP_BRANCH_HI]: begin
            dec.imm_sel   = IMM_SEXT21;
            dec.is_branch = 1'b1;
         end
         default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec.illegal = 1'b1;
`else
            dec.illegal = 1'b0;
`endif
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: 2-entry skid (main M + skid S), 1-cycle accept->out_valid, 1/cycle, in_ready registered.
// DECODE_ILLEGAL_TRAP_EN: after an illegal word is accepted, in_ready stays low until flush or reset.
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_a,
   output logic [4:0]       out_b,
   output logic [10:0]      out_c,
   output logic [4:0]       out_rd,
   output logic [1:0]       out_imm_sel,
   output logic             out_reg_write,
   output logic             out_is_branch,
   output logic             out_illegal,
   output logic [CNT_W-1:0] dec_count
);

   dec_bundle_t      in_dec;
   dec_bundle_t      m_dat, m_dat_d;
   dec_bundle_t      s_dat, s_dat_d;
   logic             m_vld, m_vld_d;
   logic             s_vld, s_vld_d;
   logic             rdy_q, rdy_d;
   logic             accept, consume;
   logic [CNT_W-1:0] cnt_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic             trap_q, trap_d;
`endif

   opcode_decode u_dec (
      .instr (in_instr),
      .dec   (in_dec)
   );

   assign accept  = in_valid && rdy_q;
   assign consume = m_vld && out_ready;

   always_comb begin
      m_vld_d = m_vld;
      m_dat_d = m_dat;
      s_vld_d = s_vld;
      s_dat_d = s_dat;
`ifdef DECODE_ILLEGAL_TRAP_EN
      trap_d  = trap_q;
`endif
      if (flush) begin
         m_vld_d = 1'b0;
         s_vld_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         trap_d  = 1'b0;
`endif
      end else begin
         if (consume) begin
            // in_ready is low whenever S is occupied, so S refill and accept never collide
            if (s_vld) begin
               m_dat_d = s_dat;
               s_vld_d = 1'b0;
            end else if (accept) begin
               m_dat_d = in_dec;
            end else begin
               m_vld_d = 1'b0;
            end
         end else if (accept) begin
            if (m_vld) begin
               s_vld_d = 1'b1;
               s_dat_d = in_dec;
            end else begin
               m_vld_d = 1'b1;
               m_dat_d = in_dec;
            end
         end
`ifdef DECODE_ILLEGAL_TRAP_EN
         if (accept && in_dec.illegal) begin
            trap_d = 1'b1;
         end
`endif
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign rdy_d = !s_vld_d && !trap_d;
`else
   assign rdy_d = !s_vld_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_vld <= 1'b0;
         s_vld <= 1'b0;
         m_dat <= '0;
         s_dat <= '0;
         rdy_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         m_vld <= m_vld_d;
         s_vld <= s_vld_d;
         m_dat <= m_dat_d;
         s_dat <= s_dat_d;
         rdy_q <= rdy_d;
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, consume};
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end
`endif

   assign in_ready      = rdy_q;
   assign out_valid     = m_vld;
   assign out_a         = m_dat.a;
   assign out_b         = m_dat.b;
   assign out_c         = m_dat.c;
   assign out_rd        = m_dat.rd;
   assign out_imm_sel   = m_dat.imm_sel;
   assign out_reg_write = m_dat.reg_write;
   assign out_is_branch = m_dat.is_branch;
   assign out_illegal   = m_dat.illegal;
   assign dec_count     = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: decode table, skid/flush/trap sequences, random traffic, counter wrap.
// Reference is a word queue (max 2 deep) with decode taken straight from the opcode ranges.
module tb_instr_decode_stage;

   localparam int CNT_W = 16;
`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, flush, in_valid, out_ready;
   logic [31:0]      in_instr;
   logic             in_ready, out_valid;
   logic [4:0]       out_a, out_b, out_rd;
   logic [10:0]      out_c;
   logic [1:0]       out_imm_sel;
   logic             out_reg_write, out_is_branch, out_illegal;
   logic [CNT_W-1:0] dec_count;

   always #5 clk = ~clk;

   instr_decode_stage #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_instr      (in_instr),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_a         (out_a),
      .out_b         (out_b),
      .out_c         (out_c),
      .out_rd        (out_rd),
      .out_imm_sel   (out_imm_sel),
      .out_reg_write (out_reg_write),
      .out_is_branch (out_is_branch),
      .out_illegal   (out_illegal),
      .dec_count     (dec_count)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0]      mq[$];
   logic [CNT_W-1:0] m_cnt;
   bit               m_trap;
   logic [25:0]      taken[$];

   typedef struct {
      logic [4:0]  a, b, rd;
      logic [10:0] c;
      logic [1:0]  sel;
      logic        rw, br, ill;
   } exp_t;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [10:0] c;
      logic [4:0]  b, a;
      logic [1:0]  sel;
      logic        rw, br, undef;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t ref_dec(input logic [31:0] w);
      exp_t e;
      int   op;
      op    = int'(w >> 26);
      e.a   = w[4:0];
      e.b   = w[9:5];
      e.c   = w[20:10];
      e.rd  = w[25:21];
      e.sel = 2'd0; e.rw = 1'b0; e.br = 1'b0; e.ill = 1'b0;
      if (op < 16)       begin e.rw = 1'b1; end
      else if (op == 16) begin e.sel = 2'd1; e.rw = 1'b1; end
      else if (op < 32)  begin e.sel = 2'd2; e.rw = 1'b1; end
      else if (op < 40)  begin e.sel = 2'd3; e.br = 1'b1; end
      else               begin e.ill = TRAP; end
      return e;
   endfunction

   function automatic bit m_rdy();
      return (mq.size() < 2) && !m_trap;
   endfunction

   task automatic check_state();
      exp_t e;
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(m_rdy()));
      chk("dec_count", 32'(dec_count), 32'(m_cnt));
      if (mq.size() > 0) begin
         e = ref_dec(mq[0]);
         chk("out_a", 32'(out_a), 32'(e.a));
         chk("out_b", 32'(out_b), 32'(e.b));
         chk("out_c", 32'(out_c), 32'(e.c));
         chk("out_rd", 32'(out_rd), 32'(e.rd));
         chk("out_imm_sel", 32'(out_imm_sel), 32'(e.sel));
         chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
         chk("out_is_branch", 32'(out_is_branch), 32'(e.br));
         chk("out_illegal", 32'(out_illegal), 32'(e.ill));
      end
   endtask

   // one clock: drive after the falling edge, update the reference at the rising edge, check at the next falling edge
   task automatic cyc(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
      bit acc, cons;
      in_valid  = v;
      in_instr  = w;
      out_ready = ordy;
      flush     = fl;
      if (out_valid && ordy) taken.push_back({out_rd, out_c, out_b, out_a});
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_cnt  = '0;
         m_trap = 1'b0;
      end else begin
         acc  = v && m_rdy();
         cons = (mq.size() > 0) && ordy;
         if (cons) begin
            m_cnt = m_cnt + 1'b1;
            void'(mq.pop_front());
         end
         if (fl) begin
            mq.delete();
            m_trap = 1'b0;
         end else if (acc) begin
            mq.push_back(w);
            if (TRAP && w[31:26] >= 6'h28) m_trap = 1'b1;
         end
      end
      @(negedge clk);
      check_state();
   endtask

   function automatic logic [31:0] legal_word();
      logic [5:0]  op;
      logic [25:0] lo;
      op = 6'($urandom_range(0, 39));
      lo = 26'($urandom);
      return {op, lo};
   endfunction

   initial begin
      vec_t        tbl[10];
      logic [31:0] w;
      logic [31:0] bw[4];
      logic [31:0] w_ill;
      logic [CNT_W-1:0] base;
      int          idx;
      bit          r;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      m_cnt = '0; m_trap = 1'b0;

      // reset held two cycles with fetch presenting a word
      cyc(1'b1, 32'h4800_0001, 1'b0, 1'b0);
      cyc(1'b1, 32'h4800_0001, 1'b0, 1'b0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_dec_count", 32'(dec_count), 32'd0);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      chk("rst_out_c", 32'(out_c), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_imm_sel", 32'(out_imm_sel), 32'd0);
      chk("rst_flags", 32'({out_reg_write, out_is_branch, out_illegal}), 32'd0);
      rst_n = 1'b1;

      tbl[0] = '{6'h00, 5'h01, 11'h001, 5'h02, 5'h03, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{6'h0F, 5'h1F, 11'h7FF, 5'h1F, 5'h1F, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{6'h10, 5'h0A, 11'h555, 5'h15, 5'h0A, 2'd1, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{6'h11, 5'h0D, 11'h2F3, 5'h0F, 5'h0F, 2'd2, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{6'h1F, 5'h00, 11'h400, 5'h10, 5'h01, 2'd2, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{6'h20, 5'h03, 11'h123, 5'h04, 5'h05, 2'd3, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{6'h27, 5'h1E, 11'h0FF, 5'h00, 5'h1E, 2'd3, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{6'h28, 5'h02, 11'h002, 5'h02, 5'h02, 2'd0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{6'h30, 5'h07, 11'h321, 5'h09, 5'h11, 2'd0, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{6'h3F, 5'h15, 11'h6AB, 5'h0C, 5'h1B, 2'd0, 1'b0, 1'b0, 1'b1};

      foreach (tbl[i]) begin
         w = {tbl[i].op, tbl[i].rd, tbl[i].c, tbl[i].b, tbl[i].a};
         cyc(1'b1, w, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("tbl%0d_a", i), 32'(out_a), 32'(tbl[i].a));
         chk($sformatf("tbl%0d_b", i), 32'(out_b), 32'(tbl[i].b));
         chk($sformatf("tbl%0d_c", i), 32'(out_c), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_rd", i), 32'(out_rd), 32'(tbl[i].rd));
         chk($sformatf("tbl%0d_sel", i), 32'(out_imm_sel), 32'(tbl[i].sel));
         chk($sformatf("tbl%0d_rw", i), 32'(out_reg_write), 32'(tbl[i].rw));
         chk($sformatf("tbl%0d_br", i), 32'(out_is_branch), 32'(tbl[i].br));
         chk($sformatf("tbl%0d_ill", i), 32'(out_illegal), 32'(TRAP & tbl[i].undef));
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(!(TRAP & tbl[i].undef)));
         cyc(1'b0, '0, 1'b1, 1'b0);
         cyc(1'b0, '0, 1'b0, 1'b1);
      end

      // backpressure: four words offered against a stalled consumer
      foreach (bw[k]) bw[k] = {6'h01, 21'h0, 5'(k + 3)};
      base = m_cnt;
      idx  = 0;
      for (int t = 0; t < 4; t++) begin
         r = m_rdy();
         cyc(1'b1, bw[idx & 3], 1'b0, 1'b0);
         if (r) idx++;
      end
      chk("bp_accepted", 32'(idx), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_a_held", 32'(out_a), 32'd3);
      taken.delete();
      for (int t = 0; t < 20 && taken.size() < 4; t++) begin
         r = m_rdy();
         cyc(idx < 4, bw[idx & 3], 1'b1, 1'b0);
         if (r && idx < 4) idx++;
      end
      chk("bp_taken_count", 32'(taken.size()), 32'd4);
      foreach (taken[k]) chk($sformatf("bp_order%0d", k), 32'(taken[k]), 32'(bw[k & 3][25:0]));
      chk("bp_dec_count", 32'(dec_count), 32'(CNT_W'(base + 4)));

      // flush with both entries full and a word offered in the same cycle
      cyc(1'b1, 32'h0400_0011, 1'b0, 1'b0);
      cyc(1'b1, 32'h0400_0012, 1'b0, 1'b0);
      chk("fl_full_in_ready", 32'(in_ready), 32'd0);
      taken.delete();
      cyc(1'b1, 32'h0BAD_F00D, 1'b0, 1'b1);
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      for (int t = 0; t < 3; t++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fl_no_leak", 32'(taken.size()), 32'd0);
      cyc(1'b1, 32'h0400_0013, 1'b0, 1'b0);
      base = m_cnt;
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("fl_consume_counts", 32'(dec_count), 32'(CNT_W'(base + 1)));

      // illegal opcode 0x30 followed by legal traffic
      w_ill = 32'hC0AB_CDEF;
      cyc(1'b1, w_ill, 1'b0, 1'b0);
      chk("ill_flag", 32'(out_illegal), 32'(TRAP));
      chk("ill_imm_sel", 32'(out_imm_sel), 32'd0);
      chk("ill_reg_write", 32'(out_reg_write), 32'd0);
      chk("ill_in_ready", 32'(in_ready), 32'(!TRAP));
      taken.delete();
      for (int t = 0; t < 3; t++) cyc(1'b1, 32'h0800_0000 | 32'(t), 1'b1, 1'b0);
      chk("ill_in_ready_hold", 32'(in_ready), 32'(!TRAP));
      chk("ill_passed_count", 32'(taken.size()), TRAP ? 32'd1 : 32'd3);
      chk("ill_passed_word", 32'(taken[0]), 32'(w_ill[25:0]));
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("ill_flush_ready", 32'(in_ready), 32'd1);

      // random traffic with occasional flush and reset
      for (int t = 0; t < 3000; t++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 29) == 0);
      end
      rst_n = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b1);

      // counter wrap at 2^CNT_W
      for (int t = 0; t < 70000 && m_cnt != {CNT_W{1'b1}}; t++) cyc(1'b1, legal_word(), 1'b1, 1'b0);
      chk("wrap_pre", 32'(dec_count), 32'h0000_FFFF);
      chk("wrap_pre_valid", 32'(out_valid), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_zero", 32'(dec_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
